l2_req_gen: RTL
===============

L2_REQ_GEN -- requirements
Module: l2_req_gen

Interface
REQ-001 SHALL have parameter max_out, default 16: maximum outstanding OpenCAPI reads, a power of two.
REQ-002 SHALL have parameter tag_width, default $clog2(max_out): command and response tag width.
REQ-003 SHALL have parameter cl_bytes, default 128: cacheline size in bytes.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have ports i_cfg_v in 1, i_cfg_r out 1, i_cfg_base in 64 (stream base EA, cl_bytes aligned) and i_cfg_ncl in 32 (stream length in cachelines).
REQ-007 SHALL have ports i_req_v in 1 and i_req_r out 1: one-cacheline fetch request from l2_stream_ptr o_req.
REQ-008 SHALL have ports o_cmd_v out 1, o_cmd_r in 1, o_cmd_ea out 64 and o_cmd_tag out tag_width: OpenCAPI 3.0 read command.
REQ-009 SHALL have ports i_rsp_v in 1, i_rsp_r out 1 and i_rsp_tag in tag_width: OpenCAPI 3.0 read completion, possibly out of order.
REQ-010 SHALL have ports o_rsp_v out 1, o_rsp_r in 1 and o_rsp_tag out tag_width: in-order completion to l2_stream_ptr i_rsp.
REQ-011 SHALL have port o_err out 1: sticky flag for an unexpected response tag.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
- IDLE to RUN on an accepted cfg with ncl>0.
- Any state to DONE on an accepted cfg with ncl=0.
- RUN to DONE when issued count reaches ncl.
REQ-013 SHALL drive i_cfg_r=1 only when outstanding=0 and o_cmd_v=0, in any state.
REQ-014 SHALL, on cfg accept, load base and ncl and clear the issued count, tail and head.
REQ-015 SHALL drive i_req_r=1 only when all of the following hold:
- state=RUN;
- issued<ncl;
- outstanding<max_out;
- o_cmd_v=0 or o_cmd_r=1.
REQ-016 SHALL, on i_req accept, register the command in the next cycle:
- o_cmd_v=1;
- o_cmd_ea=base+issued*cl_bytes (64-bit wrap);
- o_cmd_tag=tail.
Then issued, tail (mod max_out) and outstanding each increment. Latency is 1 cycle; throughput is 1 per cycle.
REQ-017 SHALL hold o_cmd_v, o_cmd_ea and o_cmd_tag stable while o_cmd_v=1 and o_cmd_r=0.
REQ-018 SHALL count outstanding from i_req accept until o_rsp retire, within 0..max_out.
REQ-019 SHALL drive i_rsp_r=1 constantly; on i_rsp_v it sets done[i_rsp_tag].
REQ-020 SHALL treat an i_rsp_tag that is not in flight, or whose done bit is already set, as an error: set o_err and leave state unchanged.
REQ-021 SHALL drive o_rsp_v=done[head] from registered state, with o_rsp_tag=head.
- Minimum latency from i_rsp (tag=head) to o_rsp_v is 1 cycle.
REQ-022 SHALL, on o_rsp_v and o_rsp_r, clear done[head], increment head mod max_out and decrement outstanding.
REQ-023 SHALL leave outstanding unchanged when an issue and a retire occur in the same cycle.
REQ-024 SHALL honour both updates when a response for tag t and a retire of tag t' are in the same cycle (t≠t').
REQ-025 SHALL release completions strictly in issue order, regardless of response order.
REQ-026 SHALL hold i_req_r=0 in DONE and IDLE.
- Completions still retire in DONE.
- A new cfg requires outstanding=0.

Reset
REQ-027 SHALL, while reset=0, asynchronously force:
- state=IDLE;
- issued=0, head=0, tail=0, outstanding=0;
- all done bits 0;
- o_cmd_v=0, o_rsp_v=0, o_err=0;
- o_cmd_ea=0, o_cmd_tag=0, o_rsp_tag=0;
- i_cfg_r=0, i_req_r=0, i_rsp_r=0.
REQ-028 SHALL, after reset release, drive i_cfg_r=1 and i_rsp_r=1 from the first clock edge.
REQ-029 SHALL discard all in-flight commands and completions on reset mid-operation; no o_rsp is produced for them afterwards.

Verification
REQ-030 Basic: cfg base=0x1000, ncl=3; 3 i_req with o_cmd_r=1 -> o_cmd_ea 0x1000/0x1080/0x1100 with tags 0/1/2, one cycle after each accept; then DONE with i_req_r=0.
REQ-031 Reorder: issue tags 0,1,2; respond 2,0,1 -> o_rsp_tag 0 one cycle after rsp0, then 1, then 2; outstanding returns to 0.
REQ-032 Full: max_out=16, no responses, continuous i_req -> exactly 16 commands, then i_req_r=0; one response for tag 0 retired -> i_req_r=1 next cycle.
REQ-033 Backpressure: o_cmd_r=0 for 5 cycles -> o_cmd stable, i_req_r=0; o_cmd_r=1 -> drains and accepts next i_req in the same cycle.
REQ-034 Errors and cfg: duplicate rsp tag 0 -> o_err=1 sticky, o_rsp count unchanged; cfg during outstanding=2 -> i_cfg_r=0 until both retire; cfg ncl=0 -> DONE.
REQ-035 Reset: assert reset mid-stream with 4 outstanding -> all outputs at reset values immediately; after release, no o_rsp is produced for the old tags.

Source files
------------

// File: rtl/l2_req_gen.sv
// ----------------------------------------------------------------------------
// l2_req_gen
//
// Turns one-cacheline fetch requests from l2_stream_ptr into OpenCAPI 3.0 read
// commands, tracks their completions (which may arrive out of order) and hands
// them back to l2_stream_ptr strictly in issue order.
//
// A stream is described by a base effective address and a length in
// cachelines. Each accepted request produces one read command at
// base + issued*cl_bytes. Its tag comes from a circular tail pointer. Responses
// set a per-tag done bit. A head pointer releases the oldest command once its
// done bit is set, which restores issue order.
//
// Ports
//   clk, reset                    clock, asynchronous active-low reset
//   i_cfg_v/i_cfg_r               stream configuration handshake
//   i_cfg_base, i_cfg_ncl         stream base EA (cacheline aligned), length
//   i_req_v/i_req_r               one-cacheline fetch request
//   o_cmd_v/o_cmd_r               OpenCAPI read command handshake
//   o_cmd_ea, o_cmd_tag           command effective address and tag
//   i_rsp_v/i_rsp_r, i_rsp_tag    OpenCAPI read completion (any order)
//   o_rsp_v/o_rsp_r, o_rsp_tag    in-order completion to l2_stream_ptr
//   o_err                         sticky flag: unexpected response tag seen
// ----------------------------------------------------------------------------
module l2_req_gen #(
    parameter int max_out   = 16,
    parameter int tag_width = $clog2(max_out),
    parameter int cl_bytes  = 128
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 i_cfg_v,
    output logic                 i_cfg_r,
    input  logic [63:0]          i_cfg_base,
    input  logic [31:0]          i_cfg_ncl,

    input  logic                 i_req_v,
    output logic                 i_req_r,

    output logic                 o_cmd_v,
    input  logic                 o_cmd_r,
    output logic [63:0]          o_cmd_ea,
    output logic [tag_width-1:0] o_cmd_tag,

    input  logic                 i_rsp_v,
    output logic                 i_rsp_r,
    input  logic [tag_width-1:0] i_rsp_tag,

    output logic                 o_rsp_v,
    input  logic                 o_rsp_r,
    output logic [tag_width-1:0] o_rsp_tag,

    output logic                 o_err
);

    // The outstanding counter must be able to hold max_out itself.
    localparam int                   CNT_W      = $clog2(max_out + 1);
    localparam logic [CNT_W-1:0]     OUT_MAX    = CNT_W'(max_out);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [tag_width-1:0] TAG_LAST   = tag_width'(max_out - 1);
    localparam logic [tag_width-1:0] TAG_ONE    = tag_width'(1);
    localparam logic [63:0]          LINE_BYTES = 64'(cl_bytes);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_alive;
    logic [63:0]            r_base;
    logic [31:0]            r_ncl;
    logic [31:0]            r_issued;
    logic [tag_width-1:0]   r_tail;
    logic [tag_width-1:0]   r_head;
    logic [CNT_W-1:0]       r_outstanding;
    logic [max_out-1:0]     r_done;

    logic                   r_cmd_v;
    logic [63:0]            r_cmd_ea;
    logic [tag_width-1:0]   r_cmd_tag;
    logic                   r_err;

    logic                   w_cfg_r;
    logic                   w_req_r;
    logic                   w_cfg_fire;
    logic                   w_req_fire;
    logic                   w_retire;
    logic [tag_width-1:0]   w_rsp_rel;
    logic                   w_in_flight;
    logic                   w_rsp_ok;
    logic                   w_rsp_err;
    logic [63:0]            w_issue_ea;
    logic [tag_width-1:0]   w_tail_nxt;
    logic [tag_width-1:0]   w_head_nxt;

    // ------------------------------------------------------------------------
    // Handshake decode and response classification.
    // A tag is in flight when its distance from head is below the outstanding
    // count. A response outside that window, or one whose done bit is already
    // set, is flagged as an error and otherwise ignored. Retiring needs
    // done[head]=1, so a response for head in the retire cycle is always a
    // duplicate. Updates to done[] in the same cycle therefore never collide.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cfg_fire  = i_cfg_v & w_cfg_r;
        w_req_fire  = i_req_v & w_req_r;
        w_retire    = r_done[r_head] & o_rsp_r;
        w_rsp_rel   = i_rsp_tag - r_head;
        w_in_flight = (CNT_W'(w_rsp_rel) < r_outstanding);
        w_rsp_ok    = r_alive & i_rsp_v & w_in_flight & ~r_done[i_rsp_tag];
        w_rsp_err   = r_alive & i_rsp_v & ~(w_in_flight & ~r_done[i_rsp_tag]);
        w_issue_ea  = r_base + (64'(r_issued) * LINE_BYTES);
        w_tail_nxt  = (r_tail == TAG_LAST) ? '0 : r_tail + TAG_ONE;
        w_head_nxt  = (r_head == TAG_LAST) ? '0 : r_head + TAG_ONE;
    end

    // ------------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state. A configuration takes priority. A zero-length stream
    // goes straight to DONE from any state. Otherwise the stream runs until
    // every requested cacheline has been issued.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_cfg_fire) begin
            w_state_nxt = (i_cfg_ncl == 32'd0) ? ST_DONE : ST_RUN;
        end else if ((r_state == ST_RUN) && (r_issued == r_ncl)) begin
            w_state_nxt = ST_DONE;
        end
    end

    // ------------------------------------------------------------------------
    // FSM outputs (ready signals).
    // A new configuration is only taken once the pipe is completely empty.
    // While a configuration is being accepted, requests are held off in the
    // same cycle so the new stream starts from a clean count. r_alive keeps
    // every ready low until the first clock edge after reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cfg_r = r_alive & (r_outstanding == '0) & ~r_cmd_v;
        w_req_r = (r_state == ST_RUN)
                & (r_issued < r_ncl)
                & (r_outstanding < OUT_MAX)
                & (~r_cmd_v | o_cmd_r)
                & ~(i_cfg_v & w_cfg_r);
    end

    // ------------------------------------------------------------------------
    // Stream bookkeeping: base/length, issue count and the tag ring pointers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alive  <= 1'b0;
            r_base   <= '0;
            r_ncl    <= '0;
            r_issued <= '0;
            r_tail   <= '0;
            r_head   <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_cfg_fire) begin
                r_base   <= i_cfg_base;
                r_ncl    <= i_cfg_ncl;
                r_issued <= '0;
                r_tail   <= '0;
                r_head   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_issued <= r_issued + 32'd1;
                    r_tail   <= w_tail_nxt;
                end
                if (w_retire) begin
                    r_head <= w_head_nxt;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Command output register. A new command can load in the same cycle the
    // previous one is taken. Otherwise the command holds until o_cmd_r.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_v   <= 1'b0;
            r_cmd_ea  <= '0;
            r_cmd_tag <= '0;
        end else if (w_req_fire) begin
            r_cmd_v   <= 1'b1;
            r_cmd_ea  <= w_issue_ea;
            r_cmd_tag <= r_tail;
        end else if (o_cmd_r) begin
            r_cmd_v   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outstanding count: from request acceptance to in-order retire. An issue
    // and a retire in the same cycle cancel out.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_req_fire, w_retire})
                2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Completion scoreboard and sticky error flag.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_retire) begin
                r_done[r_head] <= 1'b0;
            end
            if (w_rsp_ok) begin
                r_done[i_rsp_tag] <= 1'b1;
            end
            if (w_rsp_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign i_cfg_r   = w_cfg_r;
    assign i_req_r   = w_req_r;
    assign i_rsp_r   = r_alive;
    assign o_cmd_v   = r_cmd_v;
    assign o_cmd_ea  = r_cmd_ea;
    assign o_cmd_tag = r_cmd_tag;
    assign o_rsp_v   = r_done[r_head];
    assign o_rsp_tag = r_head;
    assign o_err     = r_err;

endmodule
